// File: rtl/register_file_if.sv
// -----------------------------------------------------------------------------
// register_file_if
// Bus between the register file and its users: the write-back stage drives the
// write port, decode drives the read indices and the issue port, and the
// hazard unit consumes the pending flags.
//
// Members:
//   reg_write        write-port enable
//   write_register   write-port destination index
//   write_data       write-port data
//   read_register_1  read port 1 index
//   read_register_2  read port 2 index
//   read_data_1      read port 1 data (combinational)
//   read_data_2      read port 2 data (combinational)
//   issue_valid      decode issues an instruction writing issue_register
//   issue_register   destination index of the issued instruction
//   pending_1        read_register_1 has an outstanding write
//   pending_2        read_register_2 has an outstanding write
//
// Modports: master (pipeline side), slave (register file side).
// -----------------------------------------------------------------------------
interface register_file_if #(
    parameter int unsigned N = 32
);
    localparam int unsigned AW = 5;

    logic          reg_write;
    logic [AW-1:0] write_register;
    logic [N-1:0]  write_data;
    logic [AW-1:0] read_register_1;
    logic [AW-1:0] read_register_2;
    logic [N-1:0]  read_data_1;
    logic [N-1:0]  read_data_2;
    logic          issue_valid;
    logic [AW-1:0] issue_register;
    logic          pending_1;
    logic          pending_2;

    modport master (
        output reg_write,
        output write_register,
        output write_data,
        output read_register_1,
        output read_register_2,
        input  read_data_1,
        input  read_data_2,
        output issue_valid,
        output issue_register,
        input  pending_1,
        input  pending_2
    );

    modport slave (
        input  reg_write,
        input  write_register,
        input  write_data,
        input  read_register_1,
        input  read_register_2,
        output read_data_1,
        output read_data_2,
        input  issue_valid,
        input  issue_register,
        output pending_1,
        output pending_2
    );
endinterface : register_file_if

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 32 x N MIPS general-purpose register file: one write port, two combinational
// read ports, and a one-bit-per-register pending-write scoreboard feeding the
// hazard unit. Register 0 is not stored and always reads 0.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    register_file_if.slave (write port, read ports, issue port,
//          pending flags)
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   defined   - a same-cycle write to a read index is forwarded to the read
//               data and suppresses that port's pending flag.
//   undefined - reads and pending flags reflect stored state only.
// -----------------------------------------------------------------------------
module register_file #(
    parameter int unsigned N        = 32,
    parameter logic [N-1:0] SP_RESET = N'(32'h7FFF_EFFC),
    parameter logic [N-1:0] GP_RESET = N'(32'h1000_8000)
) (
    input  logic                  clk,
    input  logic                  reset,
    register_file_if.slave        bus
);

    localparam int unsigned AW     = 5;
    localparam int unsigned NREG   = 32;
    localparam int unsigned GP_IDX = 28;
    localparam int unsigned SP_IDX = 29;

    // Storage for registers 1..31 and their scoreboard bits
    logic [N-1:0]   regs_q [1:NREG-1];
    logic [NREG-1:1] sb_q;
    logic [NREG-1:1] sb_d;

    logic wr_en_c;
    logic iss_en_c;

    // Writes and issues to index 0 are dropped
    assign wr_en_c  = bus.reg_write   && (bus.write_register != '0);
    assign iss_en_c = bus.issue_valid && (bus.issue_register != '0);

    // Scoreboard next state; set is applied after clear so a newer writer wins
    always_comb begin
        sb_d = sb_q;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (wr_en_c && (bus.write_register == AW'(i))) begin
                sb_d[i] = 1'b0;
            end
            if (iss_en_c && (bus.issue_register == AW'(i))) begin
                sb_d[i] = 1'b1;
            end
        end
    end

    // Register storage and scoreboard state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (i == GP_IDX) begin
                    regs_q[i] <= GP_RESET;
                end else if (i == SP_IDX) begin
                    regs_q[i] <= SP_RESET;
                end else begin
                    regs_q[i] <= '0;
                end
            end
            sb_q <= '0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (wr_en_c && (bus.write_register == AW'(i))) begin
                    regs_q[i] <= bus.write_data;
                end
            end
            sb_q <= sb_d;
        end
    end

    // Stored-state lookup for both read ports; index 0 falls through to 0
    logic [N-1:0] rd1_store_c;
    logic [N-1:0] rd2_store_c;
    logic         pd1_store_c;
    logic         pd2_store_c;

    always_comb begin
        rd1_store_c = '0;
        rd2_store_c = '0;
        pd1_store_c = 1'b0;
        pd2_store_c = 1'b0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (bus.read_register_1 == AW'(i)) begin
                rd1_store_c = regs_q[i];
                pd1_store_c = sb_q[i];
            end
            if (bus.read_register_2 == AW'(i)) begin
                rd2_store_c = regs_q[i];
                pd2_store_c = sb_q[i];
            end
        end
    end

    // Output selection, optionally forwarding the in-flight write
    always_comb begin
        bus.read_data_1 = rd1_store_c;
        bus.read_data_2 = rd2_store_c;
        bus.pending_1   = pd1_store_c;
        bus.pending_2   = pd2_store_c;
`ifdef REGFILE_BYPASS_EN
        if (wr_en_c && (bus.write_register == bus.read_register_1)) begin
            bus.read_data_1 = bus.write_data;
            bus.pending_1   = 1'b0;
        end
        if (wr_en_c && (bus.write_register == bus.read_register_2)) begin
            bus.read_data_2 = bus.write_data;
            bus.pending_2   = 1'b0;
        end
`else
        // Same-cycle write is visible from the next cycle only
`endif
    end

endmodule : register_file

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Directed self-checking bench for register_file. Expected values are
// hand-computed; bypass-dependent expectations follow REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_register_file;

    localparam int unsigned N = 32;

    logic clk;
    logic reset;

    int checks;
    int passed;

    register_file_if #(.N(N)) bus ();

    register_file #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Advance one clock; inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_data(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
        else passed++;
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%b exp=%b", name, got, exp);
        else passed++;
    endtask

    task automatic idle_inputs();
        bus.reg_write       = 1'b0;
        bus.write_register  = '0;
        bus.write_data      = '0;
        bus.issue_valid     = 1'b0;
        bus.issue_register  = '0;
    endtask

    task automatic test_reset();
        logic [N-1:0] exp1;
        logic [N-1:0] exp2;
        reset = 1'b0;
        idle_inputs();
        bus.read_register_1 = '0;
        bus.read_register_2 = '0;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            bus.read_register_1 = 5'(i);
            bus.read_register_2 = 5'(31 - i);
            #1;
            exp1 = (i == 28) ? 32'h1000_8000 : (i == 29) ? 32'h7FFF_EFFC : 32'h0;
            exp2 = ((31 - i) == 28) ? 32'h1000_8000 : ((31 - i) == 29) ? 32'h7FFF_EFFC : 32'h0;
            if (exp1 !== 32'h0 || i == 0 || i == 31) chk_data("reset_rd1", bus.read_data_1, exp1);
            if (exp2 !== 32'h0 || i == 0 || i == 31) chk_data("reset_rd2", bus.read_data_2, exp2);
            if (i == 0 || i == 31) begin
                chk_bit("reset_pend1", bus.pending_1, 1'b0);
                chk_bit("reset_pend2", bus.pending_2, 1'b0);
            end
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        bus.reg_write      = 1'b1;
        bus.write_register = 5'd5;
        bus.write_data     = 32'hDEADBEEF;
        tick();
        bus.write_register = 5'd0;
        bus.write_data     = 32'h12345678;
        tick();
        idle_inputs();
        bus.read_register_1 = 5'd5;
        bus.read_register_2 = 5'd0;
        #1;
        chk_data("wr_rd_5", bus.read_data_1, 32'hDEADBEEF);
        chk_data("wr_rd_0", bus.read_data_2, 32'h0);
        bus.read_register_2 = 5'd5;
        #1;
        chk_data("both_rd1_5", bus.read_data_1, 32'hDEADBEEF);
        chk_data("both_rd2_5", bus.read_data_2, 32'hDEADBEEF);
        tick();
    endtask

    task automatic test_bypass();
        bus.issue_valid    = 1'b1;
        bus.issue_register = 5'd7;
        bus.read_register_1 = 5'd7;
        bus.read_register_2 = 5'd7;
        tick();
        idle_inputs();
        #1;
        chk_bit("byp_pend_before", bus.pending_1, 1'b1);
        bus.reg_write      = 1'b1;
        bus.write_register = 5'd7;
        bus.write_data     = 32'hA5A5A5A5;
        #1;
        chk_data("byp_same_cycle", bus.read_data_1, BYP ? 32'hA5A5A5A5 : 32'h0);
        chk_data("byp_same_cycle2", bus.read_data_2, BYP ? 32'hA5A5A5A5 : 32'h0);
        chk_bit("byp_pend_same", bus.pending_1, BYP ? 1'b0 : 1'b1);
        tick();
        idle_inputs();
        #1;
        chk_data("byp_next_cycle", bus.read_data_1, 32'hA5A5A5A5);
        chk_bit("byp_pend_next", bus.pending_1, 1'b0);
    endtask

    task automatic test_scoreboard();
        bus.read_register_1 = 5'd9;
        bus.read_register_2 = 5'd10;
        bus.issue_valid     = 1'b1;
        bus.issue_register  = 5'd9;
        #1;
        chk_bit("sb_before_issue", bus.pending_1, 1'b0);
        tick();
        idle_inputs();
        #1;
        chk_bit("sb_t1", bus.pending_1, 1'b1);
        tick();
        tick();
        chk_bit("sb_t3", bus.pending_1, 1'b1);
        bus.reg_write      = 1'b1;
        bus.write_register = 5'd9;
        bus.write_data     = 32'h0000_0099;
        tick();
        idle_inputs();
        #1;
        chk_bit("sb_t4_clear", bus.pending_1, 1'b0);
        chk_data("sb_wb_data", bus.read_data_1, 32'h0000_0099);
        // Issue to index 0 never raises pending
        bus.read_register_1 = 5'd0;
        bus.issue_valid     = 1'b1;
        bus.issue_register  = 5'd0;
        tick();
        idle_inputs();
        #1;
        chk_bit("sb_issue0", bus.pending_1, 1'b0);
        // Two issues collapse into one bit, cleared by the first write-back
        bus.issue_valid    = 1'b1;
        bus.issue_register = 5'd10;
        tick();
        tick();
        idle_inputs();
        #1;
        chk_bit("sb_dbl_set", bus.pending_2, 1'b1);
        bus.reg_write      = 1'b1;
        bus.write_register = 5'd10;
        bus.write_data     = 32'h0000_0010;
        tick();
        idle_inputs();
        #1;
        chk_bit("sb_dbl_clear", bus.pending_2, 1'b0);
    endtask

    task automatic test_set_clear();
        bus.read_register_1 = 5'd12;
        bus.read_register_2 = 5'd11;
        bus.issue_valid     = 1'b1;
        bus.issue_register  = 5'd12;
        tick();
        #1;
        chk_bit("sc_pend_pre", bus.pending_1, 1'b1);
        bus.reg_write      = 1'b1;
        bus.write_register = 5'd12;
        bus.write_data     = 32'h0000_1212;
        tick();
        idle_inputs();
        #1;
        chk_bit("sc_pend_stays", bus.pending_1, 1'b1);
        chk_data("sc_data", bus.read_data_1, 32'h0000_1212);
        chk_bit("sc_other_idle", bus.pending_2, 1'b0);
    endtask

    task automatic test_async_reset();
        bus.reg_write      = 1'b1;
        bus.write_register = 5'd3;
        bus.write_data     = 32'h3333_3333;
        bus.issue_valid    = 1'b1;
        bus.issue_register = 5'd3;
        tick();
        bus.reg_write      = 1'b0;
        bus.issue_register = 5'd4;
        tick();
        idle_inputs();
        bus.read_register_1 = 5'd3;
        bus.read_register_2 = 5'd4;
        #1;
        chk_bit("ar_pend3_pre", bus.pending_1, 1'b1);
        chk_bit("ar_pend4_pre", bus.pending_2, 1'b1);
        chk_data("ar_data3_pre", bus.read_data_1, 32'h3333_3333);
        // Pulse reset between edges, no clock edge in the window
        #1;
        reset = 1'b0;
        #1;
        chk_bit("ar_pend3", bus.pending_1, 1'b0);
        chk_bit("ar_pend4", bus.pending_2, 1'b0);
        chk_data("ar_data3", bus.read_data_1, 32'h0);
        chk_data("ar_data12", 32'(dut.regs_q[12]), 32'h0);
        reset = 1'b1;
        // First write after release is accepted
        bus.reg_write      = 1'b1;
        bus.write_register = 5'd29;
        bus.write_data     = 32'h0BAD_F00D;
        bus.read_register_1 = 5'd29;
        bus.read_register_2 = 5'd28;
        tick();
        idle_inputs();
        #1;
        chk_data("ar_first_write", bus.read_data_1, 32'h0BAD_F00D);
        chk_data("ar_gp_after", bus.read_data_2, 32'h1000_8000);
    endtask

    task automatic test_back_to_back();
        bus.read_register_1 = 5'd31;
        bus.read_register_2 = 5'd30;
        bus.reg_write      = 1'b1;
        bus.write_register = 5'd31;
        bus.write_data     = 32'hFFFF_0001;
        tick();
        bus.write_register = 5'd30;
        bus.write_data     = 32'h8000_0000;
        tick();
        bus.write_register = 5'd31;
        bus.write_data     = 32'h0000_0002;
        tick();
        idle_inputs();
        #1;
        chk_data("b2b_r31", bus.read_data_1, 32'h0000_0002);
        chk_data("b2b_r30", bus.read_data_2, 32'h8000_0000);
    endtask

    // Bound the run in case anything stalls
    initial begin
        #50000;
        $display("FAIL timeout checks=%0d passed=%0d", checks, passed);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        passed = 0;
        reset  = 1'b0;
        idle_inputs();
        bus.read_register_1 = '0;
        bus.read_register_2 = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_set_clear();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_register_file
